// File: rtl/ap_host_pkg.sv
// Shared types and helpers for the AP host sequencer.
// Optional irq watchdog is enabled by defining AP_HOST_TIMEOUT_EN.
package ap_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WAIT,
        READ,
        DONE
    } state_e;

    localparam logic INTCOL_A = 1'b0;
    localparam logic INTCOL_B = 1'b1;

    // Number of bits needed to write value in binary (512 -> 10).
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ap_host_skid.sv
// Two-entry result buffer between the AP read port and the rd stream.
// Push and pop may happen in the same cycle, including when full.
module ap_host_skid #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic [1:0]           count_o
);

    logic [WORD_SIZE-1:0] mem_q [2];
    logic                 wp_q;
    logic                 rp_q;
    logic [1:0]           cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) mem_q[wp_q] <= data_i;
            wp_q  <= wp_q ^ push_i;
            rp_q  <= rp_q ^ pop_i;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign data_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ap_host_seq.sv
// Host-side job sequencer for the associative-processor array port.
// Define AP_HOST_TIMEOUT_EN to add an irq watchdog that aborts stuck jobs.
module ap_host_seq
    import ap_host_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int CELL_QUANT  = 512,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ADDR_W      = clogb2(CELL_QUANT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [2:0]           job_cmd,
    input  logic [1:0]           job_bank,
    input  logic [ADDR_W-1:0]    job_len,
    input  logic                 job_dir,
    input  logic                 job_target,
    input  logic                 job_rd_col,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_mode,
    output logic                 ap_op_direction,
    output logic                 ap_op_target,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_e state_q, state_d;

    logic [2:0]           cmd_q;
    logic [1:0]           bank_q;
    logic [ADDR_W-1:0]    len_q;
    logic                 dir_q;
    logic                 tgt_q;
    logic                 rdcol_q;

    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 issued_q, issued_d;
    logic                 infl_q;

    logic [ADDR_W-1:0]    waddr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 we_q;
    logic                 col_q;
    logic                 mode_q;
    logic [2:0]           apcmd_q;
    logic                 opdir_q;
    logic                 optgt_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 job_accept;
    logic                 wr_fire;
    logic                 rd_issue;
    logic                 exec_d;
    logic                 tmo_hit;
    logic                 pop;
    logic [1:0]           buf_cnt;
    logic [2:0]           occ;

    assign job_ready  = (state_q == IDLE);
    assign job_accept = job_valid & job_ready;
    assign wr_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign wr_fire    = wr_valid & wr_ready;
    assign rd_valid   = (buf_cnt != 2'd0);
    assign pop        = rd_valid & rd_ready;
    assign exec_d     = (state_d == EXEC) || (state_d == WAIT);

    // Occupancy after this cycle's pop plus the word landing at this edge.
    assign occ = 3'(buf_cnt) + 3'(infl_q) - 3'(pop);

`ifdef AP_HOST_TIMEOUT_EN
    localparam int TW = clogb2(TIMEOUT_CYC);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit = (state_q == WAIT) && !ap_state_irq &&
                     (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == WAIT) ? tmo_q + TW'(1) : '0;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        rd_issue = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (job_accept) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            end
            LOAD_A, LOAD_B: begin
                if (wr_valid) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : EXEC;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            EXEC: state_d = WAIT;
            WAIT: begin
                if (ap_state_irq) begin
                    state_d  = READ;
                    cnt_d    = '0;
                    issued_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            READ: begin
                if (!rst && !issued_q && (occ < 3'd2)) begin
                    rd_issue = 1'b1;
                    if (cnt_q == len_q) issued_d = 1'b1;
                    else                cnt_d    = cnt_q + ADDR_W'(1);
                end
                if (issued_q && !infl_q && (buf_cnt == 2'd0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            issued_q <= 1'b0;
            infl_q   <= 1'b0;
            cmd_q    <= '0;
            bank_q   <= '0;
            len_q    <= '0;
            dir_q    <= 1'b0;
            tgt_q    <= 1'b0;
            rdcol_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            col_q    <= INTCOL_A;
            mode_q   <= 1'b0;
            apcmd_q  <= '0;
            opdir_q  <= 1'b0;
            optgt_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            infl_q   <= rd_issue;
            if (job_accept) begin
                cmd_q   <= job_cmd;
                bank_q  <= job_bank;
                len_q   <= job_len;
                dir_q   <= job_dir;
                tgt_q   <= job_target;
                rdcol_q <= job_rd_col;
            end
            we_q <= wr_fire;
            if (wr_fire) begin
                waddr_q <= cnt_q;
                wdata_q <= wr_data;
            end
            // Column tracks the state the write was accepted in.
            col_q   <= (state_q == LOAD_B) ? INTCOL_B : INTCOL_A;
            mode_q  <= exec_d;
            apcmd_q <= exec_d ? cmd_q : 3'b000;
            opdir_q <= exec_d & dir_q;
            optgt_q <= exec_d & tgt_q;
            busy_q  <= (state_d != IDLE) && (state_d != DONE);
            done_q  <= (state_d == DONE);
        end
    end

    ap_host_skid #(
        .WORD_SIZE(WORD_SIZE)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (infl_q),
        .pop_i  (pop),
        .data_i (ap_data_out),
        .data_o (rd_data),
        .count_o(buf_cnt)
    );

    assign ap_addr             = (state_q == READ) ? cnt_q : waddr_q;
    assign ap_data             = wdata_q;
    assign ap_cmd              = apcmd_q;
    assign ap_sel_col          = bank_q;
    assign ap_sel_internal_col = (state_q == READ) ? rdcol_q : col_q;
    assign ap_mode             = mode_q;
    assign ap_op_direction     = opdir_q;
    assign ap_op_target        = optgt_q;
    assign ap_write_en         = we_q;
    assign ap_read_en          = rd_issue;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule
